// File: rtl/dottori_ioctl_pkg.sv
// Shared types and constants for the ioctl upload path.
`default_nettype none

package dottori_ioctl_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam int MEM_ADDR_W   = 14;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/upload_reader.sv
// Serves host ioctl upload reads of one RAM window through an arbitrated memory port.
// Optional UPLOAD_CHECKSUM_EN adds a running 16-bit sum of returned bytes on upload_sum.
`default_nettype none

module upload_reader
  import dottori_ioctl_pkg::*;
#(
  parameter logic [7:0] INDEX = 8'd2,
  parameter int         SIZE  = 16384
) (
  input  logic                    CLK_4M,
  input  logic                    nRESET,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_index,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  input  logic [7:0]              mem_data,
  output logic                    upload_active
`ifdef UPLOAD_CHECKSUM_EN
  ,
  output logic [15:0]             upload_sum
`endif
);

  state_e                  state_q, state_d;
  logic [7:0]              din_q, din_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic                    wait_q, wait_d;
  logic                    req_q, req_d;
  logic                    load_d;

  assign upload_active = ioctl_upload && (ioctl_index == INDEX);

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    // Losing the session overrides everything, including a read in the same cycle.
    if (!upload_active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ioctl_rd) begin
            if (ioctl_addr < IOCTL_ADDR_W'(SIZE)) begin
              state_d = REQ;
              addr_d  = ioctl_addr[MEM_ADDR_W-1:0];
            end else begin
              state_d = DONE;
              din_d   = FILL_BYTE;
              load_d  = 1'b1;
            end
          end
        end
        REQ:  if (mem_gnt) state_d = DATA;
        DATA: begin
          din_d   = mem_data;
          load_d  = 1'b1;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    wait_d = (state_d != IDLE);
    req_d  = (state_d == REQ);
  end

  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      addr_q  <= '0;
      wait_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;

`ifdef UPLOAD_CHECKSUM_EN
  logic        active_q;
  logic [15:0] sum_q, sum_d;

  // A byte loaded in the same cycle a session starts still counts toward the new session.
  always_comb begin
    sum_d = (upload_active && !active_q) ? 16'h0000 : sum_q;
    if (load_d) sum_d = sum_d + {8'h00, din_d};
  end

  always_ff @(posedge CLK_4M) begin
    if (!nRESET) begin
      active_q <= 1'b0;
      sum_q    <= 16'h0000;
    end else begin
      active_q <= upload_active;
      sum_q    <= sum_d;
    end
  end

  assign upload_sum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_upload_reader.sv
// Randomized and directed self-checking bench for upload_reader against a transaction-level model.
`default_nettype none

module tb_upload_reader;

  localparam int SIZE = 16384;

  logic        clk = 1'b0;
  logic        nRESET;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_gnt;
  logic [13:0] mem_addr;
  logic [7:0]  mem_data;
  logic        upload_active;
`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0] upload_sum;
`endif

  upload_reader #(.INDEX(8'd2), .SIZE(SIZE)) dut (
    .CLK_4M       (clk),
    .nRESET       (nRESET),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_index  (ioctl_index),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .upload_active(upload_active)
`ifdef UPLOAD_CHECKSUM_EN
    ,
    .upload_sum   (upload_sum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears one cycle after a granted cycle.
  logic [7:0] ram [0:SIZE-1];
  always @(posedge clk) if (mem_gnt) mem_data <= ram[mem_addr];

  int passed = 0;
  int total  = 0;

  logic [7:0]  model_din;
  logic [15:0] model_sum;
  logic [13:0] model_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic model_active();
    return ioctl_upload && (ioctl_index == 8'd2);
  endfunction

  // Called on a negedge; returns on the negedge where ioctl_wait is seen low.
  task automatic do_read(input string tag, input logic [24:0] addr, input int stalls);
    logic       act;
    logic [7:0] exp_din;
    int exp_wait, exp_req, n_wait, n_req, guard;
    act = model_active();
    if (!act) begin
      exp_din = model_din; exp_wait = 0; exp_req = 0;
    end else if (addr < SIZE) begin
      exp_din = ram[addr[13:0]]; exp_wait = 3 + stalls; exp_req = 1 + stalls;
      model_addr = addr[13:0];
    end else begin
      exp_din = 8'hFF; exp_wait = 1; exp_req = 0;
    end
    ioctl_rd = 1'b1; ioctl_addr = addr; mem_gnt = (stalls == 0);
    @(negedge clk);
    ioctl_rd = 1'b0; ioctl_addr = 25'($urandom);
    n_wait = 0; n_req = 0; guard = 0;
    while (ioctl_wait && guard < 200) begin
      n_wait++;
      if (mem_req) n_req++;
      mem_gnt = (n_wait > stalls);
      @(negedge clk);
      guard++;
    end
    mem_gnt = 1'b1;
    if (guard >= 200) chk({tag, "_timeout"}, 32'(guard), 32'd0);
    chk({tag, "_wait_cycles"}, 32'(n_wait), 32'(exp_wait));
    chk({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req));
    chk({tag, "_din"}, 32'(ioctl_din), 32'(exp_din));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(model_addr));
    if (act) begin
      model_din = exp_din;
      model_sum = model_sum + {8'h00, exp_din};
    end
  endtask

  // Ends the current session for one cycle and opens a fresh one.
  task automatic new_session();
    ioctl_upload = 1'b0;
    @(negedge clk);
    ioctl_upload = 1'b1; ioctl_index = 8'd2;
    model_sum = 16'h0000;
    @(negedge clk);
  endtask

  initial begin
    logic [24:0] a;
    for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
    ram[14'h0123] = 8'h5A;
    ram[14'h0042] = 8'h02;
    nRESET = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    ioctl_index = 8'd2; mem_gnt = 1'b1;
    model_din = 8'h00; model_sum = 16'h0000; model_addr = 14'h0000;
    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    nRESET = 1'b1; ioctl_upload = 1'b1;
    @(negedge clk);
    chk("active_on", 32'(upload_active), 32'd1);
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_start", 32'(upload_sum), 32'd0);
`endif

    do_read("basic", 25'h0123, 0);
    do_read("stall5", 25'h0123, 5);
    do_read("oor", 25'h4000, 0);

    ioctl_index = 8'd0;
    #1 chk("idx0_active", 32'(upload_active), 32'd0);
    @(negedge clk);
    do_read("idx0", 25'h0100, 0);
    new_session();

    // Abort while waiting for a grant.
    ioctl_rd = 1'b1; ioctl_addr = 25'h0200; mem_gnt = 1'b0;
    @(negedge clk);
    ioctl_rd = 1'b0;
    model_addr = 14'h0200;
    chk("abort_in_req", 32'({ioctl_wait, mem_req}), 32'b11);
    ioctl_upload = 1'b0;
    @(negedge clk);
    chk("abort_wait_req", 32'({ioctl_wait, mem_req}), 32'b00);
    chk("abort_din_kept", 32'(ioctl_din), 32'(model_din));
    mem_gnt = 1'b1;
    new_session();
    do_read("after_abort", 25'h0200, 0);

    new_session();
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_cleared", 32'(upload_sum), 32'd0);
`endif
    do_read("sum_ff", 25'h4000, 0);
    do_read("sum_02", 25'h0042, 1);
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_0101", 32'(upload_sum), 32'h0101);
`endif
    new_session();
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_new_session", 32'(upload_sum), 32'd0);
`endif

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) a = 25'($urandom_range(SIZE, 33554431));
      else a = 25'($urandom_range(0, SIZE - 1));
      do_read("rand", a, int'($urandom_range(0, 3)));
`ifdef UPLOAD_CHECKSUM_EN
      chk("rand_sum", 32'(upload_sum), 32'(model_sum));
`endif
    end

    // Reset in the middle of a transaction.
    ioctl_rd = 1'b1; ioctl_addr = 25'h0123; mem_gnt = 1'b0;
    @(negedge clk);
    ioctl_rd = 1'b0; nRESET = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", 32'({ioctl_wait, mem_req}), 32'b00);
    chk("midrst_din", 32'(ioctl_din), 32'h00);
    nRESET = 1'b1; mem_gnt = 1'b1;
    model_din = 8'h00; model_sum = 16'h0000; model_addr = 14'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_idle", 32'({ioctl_wait, mem_req}), 32'b00);
    end
    do_read("postrst", 25'h0123, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/upload_reader.md
UPLOAD_READER -- requirements
Module: upload_reader

Interface
REQ-001 SHALL have parameter INDEX, default 8'd2, meaning the ioctl_index value this block serves (NVRAM/hiscore slot).
REQ-002 SHALL have parameter SIZE, default 16384, meaning the byte count of the readable window, starting at address 0.
REQ-003 CLK_4M  in  1  system clock; every register is clocked on its rising edge.
REQ-004 nRESET  in  1  reset; synchronous, active-low.
REQ-005 ioctl_upload  in  1  the host upload session is active.
REQ-006 ioctl_rd  in  1  one-cycle read strobe; the address is valid in the same cycle.
REQ-007 ioctl_addr  in  25  byte address requested by the host.
REQ-008 ioctl_index  in  8  upload target selector.
REQ-009 ioctl_din  out  8  registered read data returned to the host.
REQ-010 ioctl_wait  out  1  high while the requested byte is not yet valid.
REQ-011 mem_req  out  1  request for the memory read port, held until granted.
REQ-012 mem_gnt  in  1  grant from the game-side arbiter.
REQ-013 mem_addr  out  14  memory byte address, registered.
REQ-014 mem_data  in  8  synchronous RAM data, valid 1 cycle after the granted cycle.
REQ-015 upload_active  out  1  high while ioctl_upload is high and ioctl_index == INDEX; the game core uses it to freeze writes.

Function
REQ-016 A read is accepted only when ioctl_rd=1, upload_active=1 and state=IDLE; an ioctl_rd in any other state SHALL be ignored.
REQ-017 States: IDLE, REQ, DATA, DONE; the encoding comes from the package.
REQ-018 IDLE->REQ on an accepted read with addr<SIZE; the block SHALL latch mem_addr=ioctl_addr[13:0] and set ioctl_wait=1 and mem_req=1 on the next edge.
REQ-019 IDLE->DONE on an accepted read with addr>=SIZE; it SHALL set ioctl_wait=1, load ioctl_din=8'hFF and issue no memory access.
REQ-020 REQ: mem_req is held high; on mem_gnt=1, mem_req SHALL drop on the next edge and the state SHALL go to DATA.
REQ-021 DATA: the block SHALL capture mem_data into ioctl_din, then go to DONE.
REQ-022 DONE: ioctl_wait SHALL drop to 0 on the next edge and the state SHALL return to IDLE.
REQ-023 The minimum latency from ioctl_rd to ioctl_wait falling SHALL be 4 edges with mem_gnt held high; each grant stall cycle adds 1.
REQ-024 ioctl_din SHALL be stable from the falling edge of ioctl_wait until the next accepted read.
REQ-025 If upload_active falls in any state, the block SHALL return to IDLE on the next edge with ioctl_wait=0 and mem_req=0; ioctl_din keeps its value.
REQ-026 If ioctl_rd and the fall of upload_active occur in the same cycle, the abort SHALL win and no read is started.
REQ-027 upload_active SHALL be combinational from ioctl_upload and ioctl_index.

Reset
REQ-028 While nRESET=0 at an edge, the block SHALL set state=IDLE, ioctl_wait=0, mem_req=0, mem_addr=0 and ioctl_din=8'h00.
REQ-029 A reset mid-transaction SHALL abandon the transaction; after reset deasserts, no stale mem_req or wait is produced.

Configuration
REQ-030 Macro UPLOAD_CHECKSUM_EN SHALL compile in port upload_sum (out, 16 bits).
REQ-031 With UPLOAD_CHECKSUM_EN defined, upload_sum SHALL be the modulo-2^16 sum of every byte loaded into ioctl_din in the DONE path.
REQ-032 With UPLOAD_CHECKSUM_EN defined, upload_sum SHALL clear to 0 on reset and on the rising edge of upload_active.
REQ-033 Without UPLOAD_CHECKSUM_EN, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package dottori_ioctl_pkg SHALL hold the state typedef, IOCTL_ADDR_W=25, MEM_ADDR_W=14 and FILL_BYTE=8'hFF.
REQ-035 The block SHALL be a single module with no sub-module; the checksum accumulator is inline.

Verification
REQ-036 The bench SHALL check: RAM[0x0123]=8'h5A, mem_gnt=1, rd at 0x0123 -> ioctl_wait high for 3 cycles, then ioctl_din=8'h5A.
REQ-037 The bench SHALL check: mem_gnt held low 5 cycles -> mem_req held, wait lasts 8 cycles, then the correct byte is returned.
REQ-038 The bench SHALL check: rd at 0x4000 (SIZE=16384) -> ioctl_din=8'hFF and mem_req never asserts.
REQ-039 The bench SHALL check: ioctl_index=8'd0 with rd -> upload_active=0, no wait and no mem_req.
REQ-040 The bench SHALL check: ioctl_upload dropped while in REQ -> next edge has wait=0 and mem_req=0; a later session reads correctly.
REQ-041 The bench SHALL check (UPLOAD_CHECKSUM_EN): read bytes 8'hFF, 8'h02 -> upload_sum=16'h0101; a new session clears it to 0.
